// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
//   DMA_PROC_BITS / DMA_ADDR_BITS : data word and BRAM address widths
//   DMA_MAX_WAIT                  : default busy cycles a debug read may wait
//   dma_state_e                   : arbiter FSM state encoding
package data_mem_arbiter_pkg;

  localparam int DMA_PROC_BITS = 32;
  localparam int DMA_ADDR_BITS = 10;
  localparam int DMA_MAX_WAIT  = 4;

  typedef enum logic {
    DMA_PIPE     = 1'b0,
    DMA_DBG_RESP = 1'b1
  } dma_state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the memory stage, the debug unit and the data BRAM.
//   pipeline side : i_pipe_mem_read/write, i_pipe_addr, i_pipe_wdata -> o_pipe_rdata, o_pipe_stall
//   debug side    : i_dbg_req, i_dbg_addr -> o_dbg_valid, o_dbg_rdata
//   BRAM side     : o_bram_we, o_bram_addr, o_bram_wdata <- i_bram_rdata
// Modport slave is the arbiter; master is everything around it.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int PROC_BITS       = DMA_PROC_BITS,
  parameter int DATA_ADDRS_BITS = DMA_ADDR_BITS
) ();

  logic                       i_pipe_mem_read;
  logic                       i_pipe_mem_write;
  logic [DATA_ADDRS_BITS-1:0] i_pipe_addr;
  logic [PROC_BITS-1:0]       i_pipe_wdata;
  logic [PROC_BITS-1:0]       o_pipe_rdata;
  logic                       o_pipe_stall;

  logic                       i_dbg_req;
  logic [DATA_ADDRS_BITS-1:0] i_dbg_addr;
  logic                       o_dbg_valid;
  logic [PROC_BITS-1:0]       o_dbg_rdata;

  logic                       o_bram_we;
  logic [DATA_ADDRS_BITS-1:0] o_bram_addr;
  logic [PROC_BITS-1:0]       o_bram_wdata;
  logic [PROC_BITS-1:0]       i_bram_rdata;

  modport slave (
    input  i_pipe_mem_read, i_pipe_mem_write, i_pipe_addr, i_pipe_wdata,
    output o_pipe_rdata, o_pipe_stall,
    input  i_dbg_req, i_dbg_addr,
    output o_dbg_valid, o_dbg_rdata,
    output o_bram_we, o_bram_addr, o_bram_wdata,
    input  i_bram_rdata
  );

  modport master (
    output i_pipe_mem_read, i_pipe_mem_write, i_pipe_addr, i_pipe_wdata,
    input  o_pipe_rdata, o_pipe_stall,
    output i_dbg_req, i_dbg_addr,
    input  o_dbg_valid, o_dbg_rdata,
    input  o_bram_we, o_bram_addr, o_bram_wdata,
    output i_bram_rdata
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Data BRAM port arbiter: the pipeline owns the single BRAM port by default,
// debug memory-dump reads are slotted into idle pipeline cycles, and a
// starvation counter forces a one-cycle pipeline stall once a pending debug
// read has waited MAX_WAIT busy cycles.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : pipeline / debug / BRAM signals (slave modport)
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int PROC_BITS       = DMA_PROC_BITS,
  parameter int DATA_ADDRS_BITS = DMA_ADDR_BITS,
  parameter int MAX_WAIT        = DMA_MAX_WAIT,
  parameter int WAIT_BITS       = $clog2(MAX_WAIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus
);

  dma_state_e                 r_state;
  dma_state_e                 w_next_state;
  logic [WAIT_BITS-1:0]       r_wait_cnt;
  logic [WAIT_BITS-1:0]       w_wait_next;

  logic                       w_pipe_busy;
  logic                       w_force;
  logic                       w_bram_we;
  logic [DATA_ADDRS_BITS-1:0] w_bram_addr;
  logic [PROC_BITS-1:0]       w_bram_wdata;
  logic                       w_pipe_stall;
  logic                       w_dbg_valid;
  logic [PROC_BITS-1:0]       w_dbg_rdata;

  assign w_pipe_busy = bus.i_pipe_mem_read | bus.i_pipe_mem_write;
  assign w_force     = bus.i_dbg_req & w_pipe_busy &
                       (r_wait_cnt == WAIT_BITS'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DMA_PIPE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wait_next  = r_wait_cnt;
    w_bram_addr  = bus.i_pipe_addr;
    w_bram_wdata = bus.i_pipe_wdata;
    w_bram_we    = bus.i_pipe_mem_write;
    w_pipe_stall = 1'b0;
    w_dbg_valid  = 1'b0;
    w_dbg_rdata  = '0;

    case (r_state)
      DMA_PIPE: begin
        if (bus.i_dbg_req && (!w_pipe_busy || w_force)) begin
          // Debug takes the port; a forced issue stalls the pipeline and
          // masks its store so it replays unchanged next cycle.
          w_bram_addr  = bus.i_dbg_addr;
          w_bram_we    = 1'b0;
          w_pipe_stall = w_force;
          w_next_state = DMA_DBG_RESP;
          w_wait_next  = '0;
        end else if (bus.i_dbg_req) begin
          w_wait_next = r_wait_cnt + 1'b1;
        end else begin
          w_wait_next = '0;
        end
      end
      DMA_DBG_RESP: begin
        // Pipeline keeps the port; a held request is ignored here so debug
        // issues are never back-to-back.
        w_dbg_valid  = 1'b1;
        w_dbg_rdata  = bus.i_bram_rdata;
        w_next_state = DMA_PIPE;
      end
      default: w_next_state = DMA_PIPE;
    endcase
  end

  assign bus.o_bram_we    = w_bram_we;
  assign bus.o_bram_addr  = w_bram_addr;
  assign bus.o_bram_wdata = w_bram_wdata;
  assign bus.o_pipe_stall = w_pipe_stall;
  assign bus.o_pipe_rdata = bus.i_bram_rdata;
  assign bus.o_dbg_valid  = w_dbg_valid;
  assign bus.o_dbg_rdata  = w_dbg_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 1-cycle synchronous BRAM model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  data_mem_arbiter_if #(.PROC_BITS(32), .DATA_ADDRS_BITS(10)) bus ();

  data_mem_arbiter #(
    .PROC_BITS(32),
    .DATA_ADDRS_BITS(10),
    .MAX_WAIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: read-before-write, 1-cycle read latency; known words are
  // loaded whenever reset is held.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h004]     <= 32'hAAAA0000;
      mem[10'h010]     <= 32'hDEADBEEF;
      mem[10'h020]     <= 32'hCAFEF00D;
      mem[10'h030]     <= 32'h0BADF00D;
      mem[10'h040]     <= 32'h44444444;
      bus.i_bram_rdata <= 32'h0;
    end else begin
      if (bus.o_bram_we) mem[bus.o_bram_addr] <= bus.o_bram_wdata;
      bus.i_bram_rdata <= mem[bus.o_bram_addr];
    end
  end

  task automatic clear_inputs();
    bus.i_pipe_mem_read  = 1'b0;
    bus.i_pipe_mem_write = 1'b0;
    bus.i_pipe_addr      = 10'h0;
    bus.i_pipe_wdata     = 32'h0;
    bus.i_dbg_req        = 1'b0;
    bus.i_dbg_addr       = 10'h0;
  endtask

  task automatic idle();
    clear_inputs();
    @(posedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h want=0", bus.o_dbg_rdata); end
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", bus.o_pipe_stall); end
    total++; if (bus.o_bram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h want=0", bus.o_bram_we); end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    bus.i_pipe_mem_write = 1'b1; bus.i_pipe_addr = 10'h050; bus.i_pipe_wdata = 32'h55AA55AA;
    #1;
    total++; if (bus.o_bram_we !== 1'b1) begin bad++; $display("FAIL pass_we got=%0h want=1", bus.o_bram_we); end
    total++; if (bus.o_bram_addr !== 10'h050) begin bad++; $display("FAIL pass_addr got=%0h want=050", bus.o_bram_addr); end
    total++; if (bus.o_bram_wdata !== 32'h55AA55AA) begin bad++; $display("FAIL pass_wdata got=%0h want=55aa55aa", bus.o_bram_wdata); end
    bus.i_pipe_mem_read = 1'b1;  // read+write together: write wins
    #1;
    total++; if (bus.o_bram_we !== 1'b1) begin bad++; $display("FAIL pass_rw_we got=%0h want=1", bus.o_bram_we); end
    @(negedge clk);
    bus.i_pipe_mem_write = 1'b0;
    #1;
    total++; if (bus.o_bram_we !== 1'b0) begin bad++; $display("FAIL pass_rd_we got=%0h want=0", bus.o_bram_we); end
    @(negedge clk);
    bus.i_pipe_mem_read = 1'b0;
    #1;
    total++; if (bus.o_pipe_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL pass_rdata got=%0h want=55aa55aa", bus.o_pipe_rdata); end
    idle();
  endtask

  task automatic test_idle_dbg();
    @(negedge clk);
    bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'h010; bus.i_pipe_addr = 10'h3FF;
    #1;
    total++; if (bus.o_bram_addr !== 10'h010) begin bad++; $display("FAIL idle_issue_addr got=%0h want=010", bus.o_bram_addr); end
    total++; if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("FAIL idle_issue_valid got=%0h want=0", bus.o_dbg_valid); end
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL idle_issue_stall got=%0h want=0", bus.o_pipe_stall); end
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("FAIL idle_resp_valid got=%0h want=1", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_resp_rdata got=%0h want=deadbeef", bus.o_dbg_rdata); end
    total++; if (bus.o_bram_addr !== 10'h3FF) begin bad++; $display("FAIL idle_resp_addr got=%0h want=3ff", bus.o_bram_addr); end
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("FAIL idle_after_valid got=%0h want=0", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'h0) begin bad++; $display("FAIL idle_after_rdata got=%0h want=0", bus.o_dbg_rdata); end
    idle();
  endtask

  // Four busy load cycles, then a store arrives exactly in the forced cycle:
  // it must be masked, debug sees the old word, and the replayed store lands.
  task automatic test_force_stall();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.i_pipe_mem_read = 1'b1; bus.i_pipe_addr = 10'h004;
      bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'h004;
      #1;
      total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL force_wait%0d_stall got=%0h want=0", c, bus.o_pipe_stall); end
    end
    @(negedge clk);
    bus.i_pipe_mem_read = 1'b0; bus.i_pipe_mem_write = 1'b1; bus.i_pipe_wdata = 32'h12345678;
    #1;
    total++; if (bus.o_pipe_stall !== 1'b1) begin bad++; $display("FAIL force_stall got=%0h want=1", bus.o_pipe_stall); end
    total++; if (bus.o_bram_we !== 1'b0) begin bad++; $display("FAIL force_we got=%0h want=0", bus.o_bram_we); end
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("FAIL force_valid got=%0h want=1", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'hAAAA0000) begin bad++; $display("FAIL force_rdata got=%0h want=aaaa0000", bus.o_dbg_rdata); end
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL force_replay_stall got=%0h want=0", bus.o_pipe_stall); end
    total++; if (bus.o_bram_we !== 1'b1) begin bad++; $display("FAIL force_replay_we got=%0h want=1", bus.o_bram_we); end
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    bus.i_pipe_mem_write = 1'b0; bus.i_pipe_mem_read = 1'b1;
    @(negedge clk);
    bus.i_pipe_mem_read = 1'b0;
    #1;
    total++; if (bus.o_pipe_rdata !== 32'h12345678) begin bad++; $display("FAIL force_commit got=%0h want=12345678", bus.o_pipe_rdata); end
    idle();
  endtask

  task automatic test_load_then_dbg();
    @(negedge clk);
    bus.i_pipe_mem_read = 1'b1; bus.i_pipe_addr = 10'h020;
    bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'h030;
    #1;
    total++; if (bus.o_bram_addr !== 10'h020) begin bad++; $display("FAIL load_addr got=%0h want=020", bus.o_bram_addr); end
    @(negedge clk);
    bus.i_pipe_mem_read = 1'b0;
    #1;
    total++; if (bus.o_bram_addr !== 10'h030) begin bad++; $display("FAIL load_dbg_addr got=%0h want=030", bus.o_bram_addr); end
    total++; if (bus.o_pipe_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL load_rdata got=%0h want=cafef00d", bus.o_pipe_rdata); end
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL load_stall got=%0h want=0", bus.o_pipe_stall); end
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("FAIL load_dbg_valid got=%0h want=1", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL load_dbg_rdata got=%0h want=0badf00d", bus.o_dbg_rdata); end
    idle();
  endtask

  task automatic test_dbg_drop();
    bus.i_pipe_mem_read = 1'b1; bus.i_pipe_addr = 10'h040; bus.i_dbg_addr = 10'h040;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.i_dbg_req = 1'b1;
      #1;
      total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL drop_pre%0d_stall got=%0h want=0", c, bus.o_pipe_stall); end
    end
    @(negedge clk);
    bus.i_dbg_req = 1'b0;
    #1;
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL drop_gap_stall got=%0h want=0", bus.o_pipe_stall); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.i_dbg_req = 1'b1;
      #1;
      total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL drop_post%0d_stall got=%0h want=0", c, bus.o_pipe_stall); end
    end
    @(negedge clk);
    #1;
    total++; if (bus.o_pipe_stall !== 1'b1) begin bad++; $display("FAIL drop_force_stall got=%0h want=1", bus.o_pipe_stall); end
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("FAIL drop_valid got=%0h want=1", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'h44444444) begin bad++; $display("FAIL drop_rdata got=%0h want=44444444", bus.o_dbg_rdata); end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'h010; bus.i_pipe_addr = 10'h3FF;
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%0h want=1", bus.o_dbg_valid); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0h want=0", bus.o_dbg_valid); end
    total++; if (bus.o_dbg_rdata !== 32'h0) begin bad++; $display("FAIL areset_rdata got=%0h want=0", bus.o_dbg_rdata); end
    total++; if (bus.o_pipe_stall !== 1'b0) begin bad++; $display("FAIL areset_stall got=%0h want=0", bus.o_pipe_stall); end
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.i_dbg_req = 1'b1;
    #1;
    // Back in PIPE: an idle-cycle request is issued straight away.
    total++; if (bus.o_bram_addr !== 10'h010) begin bad++; $display("FAIL areset_issue_addr got=%0h want=010", bus.o_bram_addr); end
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL areset_reissue_rdata got=%0h want=deadbeef", bus.o_dbg_rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic exp_valid;
      exp_valid = (i % 2 == 1);
      @(negedge clk);
      bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'h010; bus.i_pipe_addr = 10'h3FF;
      #1;
      total++; if (bus.o_dbg_valid !== exp_valid) begin bad++; $display("FAIL b2b%0d_valid got=%0h want=%0h", i, bus.o_dbg_valid, exp_valid); end
      if (i % 2 == 0) begin
        total++; if (bus.o_bram_addr !== 10'h010) begin bad++; $display("FAIL b2b%0d_addr got=%0h want=010", i, bus.o_bram_addr); end
      end else begin
        total++; if (bus.o_dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b%0d_rdata got=%0h want=deadbeef", i, bus.o_dbg_rdata); end
      end
    end
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%0h want=0", bus.o_dbg_valid); end
    idle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    idle();
    test_passthrough();
    test_idle_dbg();
    test_force_stall();
    test_load_then_dbg();
    test_dbg_drop();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
